lyra2_job_scheduler: RTL

- Sits between the input/output FIFO interface and an array of NB_OF_CORES Lyra2 cores.
- Pops fixed-length jobs from the input FIFO and dispatches each to an idle core, chosen round-robin.
- Collects fixed-length results from finished cores, also round-robin, and writes them to the output FIFO.
- Keeps per-direction job counters for debug.

---
 rtl/lyra2_job_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/lyra2_job_scheduler.sv
// Job scheduler between the input/output FIFOs and an array of Lyra2 cores.
// Dispatches fixed-length jobs and collects fixed-length results, both round-robin.
module lyra2_job_scheduler #(
    parameter int NB_OF_CORES   = 2,
    parameter int DIN_W         = 32,
    parameter int DOUT_W        = 32,
    parameter int WORDS_PER_JOB = 20,
    parameter int WORDS_PER_RES = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [DIN_W-1:0]              i_d_in,
    input  logic                          i_d_in_rdy,
    output logic                          o_d_in_rd,
    output logic [DIN_W-1:0]              o_core_d,
    output logic [NB_OF_CORES-1:0]        o_core_wr,
    input  logic [NB_OF_CORES-1:0]        i_core_busy,
    input  logic [NB_OF_CORES*DOUT_W-1:0] i_core_res,
    input  logic [NB_OF_CORES-1:0]        i_core_res_vld,
    output logic [NB_OF_CORES-1:0]        o_core_res_ack,
    output logic [DOUT_W-1:0]             o_d_out,
    output logic                          o_d_out_wr,
    input  logic                          i_d_out_rdy,
    output logic [15:0]                   o_jobs_in,
    output logic [15:0]                   o_jobs_out
);
    localparam int PTR_W  = (NB_OF_CORES > 1) ? $clog2(NB_OF_CORES) : 1;
    localparam int WCNT_W = (WORDS_PER_JOB > 1) ? $clog2(WORDS_PER_JOB) : 1;
    localparam int RCNT_W = (WORDS_PER_RES > 1) ? $clog2(WORDS_PER_RES) : 1;

    typedef enum logic {D_IDLE, D_XFER} d_state_t;
    typedef enum logic {C_IDLE, C_OUT}  c_state_t;

    // First requester at or after ptr, scanning cyclically; MSB flags a hit.
    function automatic logic [PTR_W:0] rr_pick(input logic [NB_OF_CORES-1:0] req,
                                               input logic [PTR_W-1:0] ptr);
        logic             found;
        logic [PTR_W-1:0] sel;
        logic [PTR_W-1:0] idx;
        found = 1'b0;
        sel   = '0;
        idx   = ptr;
        for (int i = 0; i < NB_OF_CORES; i++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
            idx = (idx == PTR_W'(NB_OF_CORES-1)) ? '0 : idx + 1'b1;
        end
        return {found, sel};
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] sel);
        return (sel == PTR_W'(NB_OF_CORES-1)) ? '0 : sel + 1'b1;
    endfunction

    logic [DOUT_W-1:0] res_word [NB_OF_CORES];
    generate
        for (genvar gi = 0; gi < NB_OF_CORES; gi++) begin : g_res
            assign res_word[gi] = i_core_res[gi*DOUT_W +: DOUT_W];
        end
    endgenerate

    // ---------------- dispatch side ----------------
    d_state_t                d_state_reg, d_state_next;
    logic [PTR_W-1:0]        isel_reg, in_ptr_reg;
    logic [WCNT_W-1:0]       wcnt_reg;
    logic [NB_OF_CORES-1:0]  pend_reg;
    logic [15:0]             jobs_in_reg;
    logic [DIN_W-1:0]        core_d_reg;
    logic [NB_OF_CORES-1:0]  core_wr_reg;
    logic [NB_OF_CORES-1:0]  avail, isel_onehot;
    logic [PTR_W:0]          in_pick;
    logic                    pop, pop_last;

    assign avail       = ~i_core_busy & ~pend_reg;
    assign in_pick     = rr_pick(avail, in_ptr_reg);
    assign isel_onehot = NB_OF_CORES'(1) << isel_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset) d_state_reg <= D_IDLE;
        else         d_state_reg <= d_state_next;
    end

    always_comb begin
        d_state_next = d_state_reg;
        case (d_state_reg)
            D_IDLE: if (in_pick[PTR_W]) d_state_next = D_XFER;
            D_XFER: if (pop_last)       d_state_next = D_IDLE;
            default:                    d_state_next = D_IDLE;
        endcase
    end

    always_comb begin
        o_d_in_rd = (d_state_reg == D_XFER) && i_d_in_rdy;
        pop       = o_d_in_rd;
        pop_last  = pop && (wcnt_reg == WCNT_W'(WORDS_PER_JOB-1));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            isel_reg    <= '0;
            in_ptr_reg  <= '0;
            wcnt_reg    <= '0;
            pend_reg    <= '0;
            jobs_in_reg <= '0;
            core_d_reg  <= '0;
            core_wr_reg <= '0;
        end else begin
            if (d_state_reg == D_IDLE && in_pick[PTR_W]) begin
                isel_reg <= in_pick[PTR_W-1:0];
                wcnt_reg <= '0;
            end else if (pop) begin
                wcnt_reg <= wcnt_reg + 1'b1;
            end
            if (pop) core_d_reg <= i_d_in;
            core_wr_reg <= pop ? isel_onehot : '0;
            // Set wins: pend must survive until the core's busy flag is seen.
            pend_reg <= (pend_reg & ~i_core_busy) | (pop_last ? isel_onehot : '0);
            if (pop_last) begin
                in_ptr_reg  <= next_ptr(isel_reg);
                jobs_in_reg <= jobs_in_reg + 16'd1;
            end
        end
    end

    // ---------------- collect side ----------------
    c_state_t                c_state_reg, c_state_next;
    logic [PTR_W-1:0]        osel_reg, out_ptr_reg;
    logic [RCNT_W-1:0]       rcnt_reg;
    logic [15:0]             jobs_out_reg;
    logic [DOUT_W-1:0]       d_out_reg;
    logic                    d_out_wr_reg;
    logic [PTR_W:0]          out_pick;
    logic                    ack, ack_last;

    assign out_pick = rr_pick(i_core_res_vld, out_ptr_reg);

    always_ff @(posedge i_clk) begin
        if (i_reset) c_state_reg <= C_IDLE;
        else         c_state_reg <= c_state_next;
    end

    always_comb begin
        c_state_next = c_state_reg;
        case (c_state_reg)
            C_IDLE: if (out_pick[PTR_W]) c_state_next = C_OUT;
            C_OUT:  if (ack_last)        c_state_next = C_IDLE;
            default:                     c_state_next = C_IDLE;
        endcase
    end

    always_comb begin
        ack            = (c_state_reg == C_OUT) && i_d_out_rdy;
        ack_last       = ack && (rcnt_reg == RCNT_W'(WORDS_PER_RES-1));
        o_core_res_ack = ack ? (NB_OF_CORES'(1) << osel_reg) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            osel_reg     <= '0;
            out_ptr_reg  <= '0;
            rcnt_reg     <= '0;
            jobs_out_reg <= '0;
            d_out_reg    <= '0;
            d_out_wr_reg <= 1'b0;
        end else begin
            if (c_state_reg == C_IDLE && out_pick[PTR_W]) begin
                osel_reg <= out_pick[PTR_W-1:0];
                rcnt_reg <= '0;
            end else if (ack) begin
                rcnt_reg <= rcnt_reg + 1'b1;
            end
            if (ack) d_out_reg <= res_word[osel_reg];
            d_out_wr_reg <= ack;
            if (ack_last) begin
                out_ptr_reg  <= next_ptr(osel_reg);
                jobs_out_reg <= jobs_out_reg + 16'd1;
            end
        end
    end

    assign o_core_d   = core_d_reg;
    assign o_core_wr  = core_wr_reg;
    assign o_d_out    = d_out_reg;
    assign o_d_out_wr = d_out_wr_reg;
    assign o_jobs_in  = jobs_in_reg;
    assign o_jobs_out = jobs_out_reg;

endmodule
